tmr_mac_layer: RTL and testbench
================================

Name: tmr_mac_layer

Overview:
Parametrised triple-modular-redundant fully connected neuron layer: N_OUT neurons, N_IN signed fixed-point inputs each. Three identical sequential MAC replicas compute each result; a bitwise majority voter drives the output. Per-replica disagreement is tracked with sticky flags and a saturating event counter. Successor to the fixed 8-input, two-neuron TMR top. Adds a start/valid handshake, parametrised sizes, saturation and fault reporting.

Parameters:
DATA_W, 16, width of every input, weight, bias and output word (signed two's complement)
FRAC_W, 10, fractional bits (Q6.10 by default; 16'h0400 = 1.0)
N_IN, 8, inputs per neuron
N_OUT, 2, neurons in the layer
ERR_CNT_W, 8, width of the disagreement counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a computation; sampled only in IDLE
X  in  N_IN*DATA_W  input vector, element k at [k*DATA_W +: DATA_W]
W  in  N_OUT*N_IN*DATA_W  weights, W[j][k] at [(j*N_IN+k)*DATA_W +: DATA_W]; static while busy
B  in  N_OUT*DATA_W  biases, B[j] at [j*DATA_W +: DATA_W]; static while busy
clr_fault  in  1  synchronous clear of fault_replica and err_cnt
busy  out  1  computation in progress
valid  out  1  one-cycle pulse: Y updated
Y  out  N_OUT*DATA_W  voted outputs, held until next valid
fault_replica  out  3  sticky per-replica disagreement flags
err_cnt  out  ERR_CNT_W  saturating count of computations with any disagreement

Behaviour:
- Reset (reset=0, async): FSM=IDLE, all accumulators and replica results 0; busy=0, valid=0, Y=0, fault_replica=0, err_cnt=0.
- FSM states: IDLE -> MAC -> FIN -> VOTE -> IDLE.
- IDLE: when start=1 at edge t, latch X into an internal register, clear the accumulators, set k=0, go to MAC. busy=1 from t+1.
- MAC: lasts N_IN cycles, k=0..N_IN-1. Each replica r and neuron j performs acc[r][j] += X[k]*W[j][k], signed full-precision product.
  - Accumulator width is 2*DATA_W+clog2(N_IN); no overflow is possible.
  - After k=N_IN-1, go to FIN.
- FIN (1 cycle), per replica and neuron:
  - s = acc + (sign-extended B[j] << FRAC_W).
  - Arithmetic shift right by FRAC_W (floor).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU: negative results become 0.
  - Register the result into res[r][j].
- VOTE (1 cycle):
  - Y[j] <= bitwise majority of res[0][j], res[1][j], res[2][j].
  - valid=1 for this cycle only.
  - For each r, if any res[r][j] differs from the voted value, set fault_replica[r].
  - If any replica differs, err_cnt increments by 1, saturating at all-ones.
  - Next state is IDLE; busy=0 in the following cycle.
- Latency: start at edge t -> valid high in cycle t+N_IN+2. Back-to-back period is N_IN+3 cycles.
- start while busy=1 is ignored, with no queuing. X changes while busy have no effect.
- clr_fault=1 clears fault_replica and err_cnt at the next edge.
  - If clr_fault coincides with a VOTE-cycle disagreement, the new event wins: flags are set and err_cnt=1.
- Reset asserted mid-operation aborts the computation immediately. valid is not produced and Y returns to 0.
- A triple mismatch with no majority is still resolved bitwise. All three replicas that differ from the voted word are flagged.

Optional Feature:
TMR_FAULT_INJ_EN
- Defined:
  - Adds input inj_en (1) and input inj_sel (2): replica index 0..2; value 3 means none.
  - Adds input inj_mask (DATA_W).
  - While inj_en=1 during FIN, res[inj_sel][j] is XORed with inj_mask for every j.
- Undefined: these ports do not exist and replicas are never perturbed. Otherwise behaviour is identical.

Test Plan:
- Reset sequence:
  - Apply reset=0 for 2 cycles, then release.
  - Required: Y=0, busy=0, valid=0, fault_replica=0, err_cnt=0.
- Nominal computation:
  - Stimulus: all X=16'h0400, all W=16'h0400, B=0, start at t.
  - Required: valid at t+10, Y[j]=16'h2000 for all j, busy high for cycles t+1..t+10, fault_replica=0.
- Bias, ReLU and saturation:
  - Stimulus: X=16'h0400, W[0][*]=16'hFC00 (-1.0), B[0]=16'h0400, W[1][*]=16'h7FFF, B[1]=16'h7FFF.
  - Required: Y[0]=0 (ReLU of -7.0), Y[1]=16'h7FFF (saturated).
- Busy rules:
  - Stimulus: pulse start again at t+3, and change X at t+3.
  - Required: ignored. Single valid at t+10 with the original result. Next start is accepted at t+11.
- Fault injection (TMR_FAULT_INJ_EN):
  - Stimulus: inj_sel=1, inj_mask=16'h0001, nominal inputs.
  - Required: Y=16'h2000, fault_replica=3'b010, err_cnt=1.
  - Repeat: err_cnt=2. Then apply clr_fault: flags and counter return to 0.
- Reset mid-operation:
  - Stimulus: assert reset=0 at t+5 of a computation, then restart.
  - Required: no valid, Y=0. The restarted computation completes correctly with valid N_IN+2 cycles after start.

Source files
------------

// File: rtl/tmr_mac_layer_if.sv
// Handshake/data bundle for tmr_mac_layer.
// TMR_FAULT_INJ_EN adds the inj_en/inj_sel/inj_mask fault-injection controls.
interface tmr_mac_layer_if #(
  parameter int DATA_W    = 16,
  parameter int N_IN      = 8,
  parameter int N_OUT     = 2,
  parameter int ERR_CNT_W = 8
);
  logic                          start;
  logic [N_IN*DATA_W-1:0]        X;
  logic [N_OUT*N_IN*DATA_W-1:0]  W;
  logic [N_OUT*DATA_W-1:0]       B;
  logic                          clr_fault;
  logic                          busy;
  logic                          valid;
  logic [N_OUT*DATA_W-1:0]       Y;
  logic [2:0]                    fault_replica;
  logic [ERR_CNT_W-1:0]          err_cnt;
`ifdef TMR_FAULT_INJ_EN
  logic                          inj_en;
  logic [1:0]                    inj_sel;
  logic [DATA_W-1:0]             inj_mask;

  modport master (output start, X, W, B, clr_fault, inj_en, inj_sel, inj_mask,
                  input  busy, valid, Y, fault_replica, err_cnt);
  modport slave  (input  start, X, W, B, clr_fault, inj_en, inj_sel, inj_mask,
                  output busy, valid, Y, fault_replica, err_cnt);
`else
  modport master (output start, X, W, B, clr_fault,
                  input  busy, valid, Y, fault_replica, err_cnt);
  modport slave  (input  start, X, W, B, clr_fault,
                  output busy, valid, Y, fault_replica, err_cnt);
`endif
endinterface

// File: rtl/tmr_mac_layer.sv
// Triple-modular-redundant fully connected layer: three sequential MAC replicas, bitwise voter,
// sticky per-replica fault flags and saturating disagreement counter. Option: TMR_FAULT_INJ_EN.
module tmr_mac_layer #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 10,
  parameter int N_IN      = 8,
  parameter int N_OUT     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  tmr_mac_layer_if.slave bus
);
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN);
  localparam int S_W   = ACC_W + 1;
  localparam logic signed [S_W-1:0] SAT_MAX = S_W'(2**(DATA_W-1) - 1);
  localparam logic signed [S_W-1:0] SAT_MIN = -S_W'(2**(DATA_W-1));

  typedef enum logic [1:0] {IDLE, MAC, FIN, VOTE} state_t;

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [S_W-1:0] v);
    if (v > SAT_MAX)      sat_fn = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) sat_fn = SAT_MIN[DATA_W-1:0];
    else                  sat_fn = v[DATA_W-1:0];
  endfunction

  // Bias add, floor shift back to Q format, saturate, then ReLU.
  function automatic logic signed [DATA_W-1:0] fin_fn(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [DATA_W-1:0] bias);
    logic signed [S_W-1:0]    s;
    logic signed [DATA_W-1:0] q;
    s = S_W'(acc) + (S_W'(bias) <<< FRAC_W);
    q = sat_fn(s >>> FRAC_W);
    fin_fn = q[DATA_W-1] ? '0 : q;
  endfunction

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q;
  logic [N_IN*DATA_W-1:0]     x_q;
  logic signed [ACC_W-1:0]    acc_q [3][N_OUT];
  logic signed [DATA_W-1:0]   res_q [3][N_OUT];
  logic signed [2*DATA_W-1:0] prod  [3][N_OUT];
  logic signed [DATA_W-1:0]   vote  [N_OUT];
  logic signed [DATA_W-1:0]   inj_word [3];
  logic signed [DATA_W-1:0]   x_k;
  logic [2:0]                 mism;
  logic [N_OUT*DATA_W-1:0]    y_q;
  logic [2:0]                 fault_q;
  logic [ERR_CNT_W-1:0]       err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (k_q == KW'(N_IN-1)) state_d = FIN;
      FIN:     state_d = VOTE;
      VOTE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign x_k = $signed(x_q[int'(k_q)*DATA_W +: DATA_W]);

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < N_OUT; j++)
        prod[r][j] = x_k * $signed(bus.W[(j*N_IN + int'(k_q))*DATA_W +: DATA_W]);
  end

`ifdef TMR_FAULT_INJ_EN
  always_comb begin
    for (int r = 0; r < 3; r++)
      inj_word[r] = (bus.inj_en && bus.inj_sel == 2'(r)) ? $signed(bus.inj_mask) : '0;
  end
`else
  always_comb begin
    for (int r = 0; r < 3; r++) inj_word[r] = '0;
  end
`endif

  // MAC / FIN stage: per-replica accumulate, then finalise into res_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
      x_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int j = 0; j < N_OUT; j++) begin
          acc_q[r][j] <= '0;
          res_q[r][j] <= '0;
        end
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          x_q <= bus.X;
          k_q <= '0;
          for (int r = 0; r < 3; r++)
            for (int j = 0; j < N_OUT; j++) acc_q[r][j] <= '0;
        end
        MAC: begin
          k_q <= k_q + 1'b1;
          for (int r = 0; r < 3; r++)
            for (int j = 0; j < N_OUT; j++)
              acc_q[r][j] <= acc_q[r][j] + ACC_W'(prod[r][j]);
        end
        FIN: begin
          for (int r = 0; r < 3; r++)
            for (int j = 0; j < N_OUT; j++)
              res_q[r][j] <= fin_fn(acc_q[r][j], $signed(bus.B[j*DATA_W +: DATA_W])) ^ inj_word[r];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mism = '0;
    for (int j = 0; j < N_OUT; j++) begin
      vote[j] = (res_q[0][j] & res_q[1][j]) | (res_q[0][j] & res_q[2][j]) | (res_q[1][j] & res_q[2][j]);
      for (int r = 0; r < 3; r++)
        if (res_q[r][j] != vote[j]) mism[r] = 1'b1;
    end
  end

  // VOTE stage: publish voted word and record disagreements
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q     <= '0;
      fault_q <= '0;
      err_q   <= '0;
    end else begin
      if (state_q == VOTE)
        for (int j = 0; j < N_OUT; j++) y_q[j*DATA_W +: DATA_W] <= vote[j];
      if (state_q == VOTE && |mism) begin
        fault_q <= (bus.clr_fault ? 3'b000 : fault_q) | mism;
        if (bus.clr_fault)   err_q <= ERR_CNT_W'(1);
        else if (err_q != '1) err_q <= err_q + 1'b1;
      end else if (bus.clr_fault) begin
        fault_q <= '0;
        err_q   <= '0;
      end
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.valid         = (state_q == VOTE);
  assign bus.Y             = y_q;
  assign bus.fault_replica = fault_q;
  assign bus.err_cnt       = err_q;
endmodule

// File: tb/tb_tmr_mac_layer.sv
// Directed self-checking bench for tmr_mac_layer; fault-injection scenario built with TMR_FAULT_INJ_EN.
module tb_tmr_mac_layer;
  localparam int DW = 16;
  localparam int NI = 8;
  localparam int NO = 2;
  localparam int EW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  tmr_mac_layer_if #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .ERR_CNT_W(EW)) bus ();

  tmr_mac_layer #(.DATA_W(DW), .FRAC_W(10), .N_IN(NI), .N_OUT(NO), .ERR_CNT_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] xv, input logic [DW-1:0] w0, input logic [DW-1:0] b0,
                      input logic [DW-1:0] w1, input logic [DW-1:0] b1);
    for (int k = 0; k < NI; k++) begin
      bus.X[k*DW +: DW]        = xv;
      bus.W[k*DW +: DW]        = w0;
      bus.W[(NI+k)*DW +: DW]   = w1;
    end
    bus.B[0 +: DW]  = b0;
    bus.B[DW +: DW] = b1;
  endtask

  // Pulses start and waits (bounded) for valid; lat counts cycles after the sampling edge.
  task automatic pulse_and_wait(output int lat);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.valid && lat < 40) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.Y !== '0) begin errors++; $display("FAIL reset_Y got %h want 0", bus.Y); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.fault_replica !== 3'b000) begin errors++; $display("FAIL reset_fault got %b want 000", bus.fault_replica); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_nominal();
    load(16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      checks++;
      if (bus.busy !== (i <= 10)) begin errors++; $display("FAIL nom_busy cycle %0d got %b want %b", i, bus.busy, (i <= 10)); end
      checks++;
      if (bus.valid !== (i == 10)) begin errors++; $display("FAIL nom_valid cycle %0d got %b want %b", i, bus.valid, (i == 10)); end
      if (i < 11) step();
    end
    checks++; if (bus.Y[0 +: DW] !== 16'h2000) begin errors++; $display("FAIL nom_y0 got %h want 2000", bus.Y[0 +: DW]); end
    checks++; if (bus.Y[DW +: DW] !== 16'h2000) begin errors++; $display("FAIL nom_y1 got %h want 2000", bus.Y[DW +: DW]); end
    checks++; if (bus.fault_replica !== 3'b000) begin errors++; $display("FAIL nom_fault got %b want 000", bus.fault_replica); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL nom_err got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_bias_relu_sat();
    int lat;
    load(16'h0400, 16'hFC00, 16'h0400, 16'h7FFF, 16'h7FFF);
    pulse_and_wait(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL brs_latency got %0d want 10", lat); end
    checks++; if (bus.Y[0 +: DW] !== 16'h0000) begin errors++; $display("FAIL brs_relu got %h want 0000", bus.Y[0 +: DW]); end
    checks++; if (bus.Y[DW +: DW] !== 16'h7FFF) begin errors++; $display("FAIL brs_sat got %h want 7fff", bus.Y[DW +: DW]); end
  endtask

  // 0.5*2.0*8 + 0.25 = 8.25 -> 0x2100 ; 0x200*3*8 = 12288 >> 10 = 12, +5 -> 0x0011
  task automatic test_mixed();
    int lat;
    load(16'h0200, 16'h0800, 16'h0100, 16'h0003, 16'h0005);
    pulse_and_wait(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL mix_latency got %0d want 10", lat); end
    checks++; if (bus.Y[0 +: DW] !== 16'h2100) begin errors++; $display("FAIL mix_y0 got %h want 2100", bus.Y[0 +: DW]); end
    checks++; if (bus.Y[DW +: DW] !== 16'h0011) begin errors++; $display("FAIL mix_y1 got %h want 0011", bus.Y[DW +: DW]); end
  endtask

  task automatic test_busy_rules();
    int nvalid;
    int lat;
    nvalid = 0;
    load(16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (bus.valid) begin
        nvalid++;
        checks++;
        if (i != 10) begin errors++; $display("FAIL busy_valid_cycle got %0d want 10", i); end
      end
      if (i == 3) begin
        bus.start = 1'b1;
        load(16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
      end
      if (i == 4) bus.start = 1'b0;
      if (i == 11) begin
        checks++; if (bus.Y[0 +: DW] !== 16'h2000) begin errors++; $display("FAIL busy_orig_y0 got %h want 2000", bus.Y[0 +: DW]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", bus.busy); end
        bus.start = 1'b1;
      end
      if (i == 12) begin
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_restart got %b want 1", bus.busy); end
      end
      if (i < 12) step();
    end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL busy_valid_count got %0d want 1", nvalid); end
    lat = 12;
    while (!bus.valid && lat < 60) begin
      step();
      lat++;
    end
    checks++; if (lat !== 21) begin errors++; $display("FAIL busy_second_latency got %0d want 21", lat); end
    step();
    checks++; if (bus.Y !== '0) begin errors++; $display("FAIL busy_second_y got %h want 0", bus.Y); end
  endtask

`ifdef TMR_FAULT_INJ_EN
  task automatic test_fault_inj();
    int lat;
    load(16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    bus.inj_en = 1'b1; bus.inj_sel = 2'd1; bus.inj_mask = 16'h0001;
    pulse_and_wait(lat);
    checks++; if (bus.Y !== {16'h2000, 16'h2000}) begin errors++; $display("FAIL inj_y got %h want 20002000", bus.Y); end
    checks++; if (bus.fault_replica !== 3'b010) begin errors++; $display("FAIL inj_fault got %b want 010", bus.fault_replica); end
    checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL inj_err1 got %0d want 1", bus.err_cnt); end
    pulse_and_wait(lat);
    checks++; if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL inj_err2 got %0d want 2", bus.err_cnt); end
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    checks++; if (bus.fault_replica !== 3'b000) begin errors++; $display("FAIL clr_fault got %b want 000", bus.fault_replica); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err got %0d want 0", bus.err_cnt); end
    pulse_and_wait(lat);
    bus.inj_sel = 2'd2;
    bus.clr_fault = 1'b1;
    pulse_and_wait(lat);
    bus.clr_fault = 1'b0;
    checks++; if (bus.fault_replica !== 3'b100) begin errors++; $display("FAIL clr_coincide_fault got %b want 100", bus.fault_replica); end
    checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL clr_coincide_err got %0d want 1", bus.err_cnt); end
    bus.inj_en = 1'b0; bus.inj_sel = 2'd3; bus.inj_mask = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    load(16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    reset = 1'b0;
    #1;
    checks++; if (bus.Y !== '0) begin errors++; $display("FAIL mid_y got %h want 0", bus.Y); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_valid cycle %0d got %b want 0", i, bus.valid); end
      if (i == 1) reset = 1'b1;
      step();
    end
    checks++; if (bus.Y !== '0) begin errors++; $display("FAIL mid_y_after got %h want 0", bus.Y); end
    pulse_and_wait(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL mid_restart_latency got %0d want 10", lat); end
    checks++; if (bus.Y !== {16'h2000, 16'h2000}) begin errors++; $display("FAIL mid_restart_y got %h want 20002000", bus.Y); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.clr_fault = 1'b0;
    bus.X = '0;
    bus.W = '0;
    bus.B = '0;
`ifdef TMR_FAULT_INJ_EN
    bus.inj_en = 1'b0;
    bus.inj_sel = 2'd3;
    bus.inj_mask = '0;
`endif
    test_reset();
    test_nominal();
    test_bias_relu_sat();
    test_busy_rules();
`ifdef TMR_FAULT_INJ_EN
    test_fault_inj();
`endif
    test_mixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
